// File: rtl/vmem_scan_ctrl.sv
// vmem_scan_ctrl: VGA timing generator and raster read sequencer for the video memory.
// Latency: pins (colour/sync/blank) lag the scan position by 2 pixel ticks; frame_start leads colour by 1 tick.
// Backpressure: none; free-running scan. en=0 or reset holds every register at its reset value.
// Optional build macro VMEM_SCAN_TESTPAT_EN adds test_mode (8-bar colour pattern instead of vmem data).
module vmem_scan_ctrl #(
  parameter int CLK_DIV  = 2,
  parameter int READ_LAT = 1,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int IMG_W    = 512,
  parameter int IMG_H    = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic [17:0] pxlAddr,
  input  logic [7:0]  R,
  input  logic [7:0]  G,
  input  logic [7:0]  B,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        hsync,
  output logic        vsync,
  output logic        blank_n,
  output logic        frame_start
`ifdef VMEM_SCAN_TESTPAT_EN
  ,
  input  logic        test_mode
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [H_W-1:0]   H_LAST   = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0]   H_ACT    = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0]   H_IMG    = H_W'(IMG_W);
  localparam logic [H_W-1:0]   HS_BEG   = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0]   HS_END   = H_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_W-1:0]   V_LAST   = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0]   V_ACT    = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0]   V_IMG    = V_W'(IMG_H);
  localparam logic [V_W-1:0]   VS_BEG   = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0]   VS_END   = V_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [17:0]      ADDR_LAST = 18'(IMG_W * IMG_H - 1);

  // Read data is sampled one pixel tick after the address moves, so the
  // memory must answer within CLK_DIV clocks.
  if (READ_LAT < 0 || READ_LAT > 1 || READ_LAT >= CLK_DIV ||
      IMG_W > H_ACTIVE || IMG_H > V_ACTIVE || IMG_W * IMG_H > 2**18) begin : g_cfg_err
    $error("vmem_scan_ctrl: illegal READ_LAT/CLK_DIV/image size combination");
  end

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [H_W-1:0]   hcnt_q, hcnt_d;
  logic [V_W-1:0]   vcnt_q, vcnt_d;
  logic [17:0]      pxl_addr_q, pxl_addr_d;
  logic             frame_start_q, frame_start_d;
  logic             in_img_d_q, in_img_d_d;
  logic             act_d_q, act_d_d;
  logic             hs_d_q, hs_d_d;
  logic             vs_d_q, vs_d_d;
  logic [23:0]      vga_rgb_q, vga_rgb_d;
  logic             blank_n_q, blank_n_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
`ifdef VMEM_SCAN_TESTPAT_EN
  localparam int BAR_W = H_ACTIVE / 8;
  logic [2:0]       bar_d_q, bar_d_d;
  logic [2:0]       bar;
`endif

  logic        tick;
  logic        in_img, act, hs, vs, at_origin;
  logic [23:0] pix_src;
  logic        pix_show;

  // Position decode for the pixel currently addressed by the counters.
  always_comb begin
    tick      = (div_cnt_q == DIV_LAST);
    in_img    = (hcnt_q < H_IMG) && (vcnt_q < V_IMG);
    act       = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
    hs        = (hcnt_q >= HS_BEG) && (hcnt_q < HS_END);
    vs        = (vcnt_q >= VS_BEG) && (vcnt_q < VS_END);
    at_origin = (hcnt_q == '0) && (vcnt_q == '0);
`ifdef VMEM_SCAN_TESTPAT_EN
    // Bar index = number of bar boundaries at or left of hcnt.
    bar = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (hcnt_q >= H_W'(k * BAR_W)) bar = bar + 3'd1;
    end
`endif
  end

  // Stage-1 colour source: vmem data, or the bar pattern when test_mode is set.
  always_comb begin
    pix_src  = {R, G, B};
    pix_show = in_img_d_q && act_d_q;
`ifdef VMEM_SCAN_TESTPAT_EN
    if (test_mode) begin
      // White, yellow, cyan, green, magenta, red, blue, black.
      pix_src  = {{8{~bar_d_q[1]}}, {8{~bar_d_q[2]}}, {8{~bar_d_q[0]}}};
      pix_show = act_d_q;
    end
`endif
  end

  // Next state: counters, stage-0 address/flags and stage-1 pin registers, all gated by tick.
  always_comb begin
    div_cnt_d     = div_cnt_q + DIV_W'(1);
    hcnt_d        = hcnt_q;
    vcnt_d        = vcnt_q;
    pxl_addr_d    = pxl_addr_q;
    frame_start_d = 1'b0;
    in_img_d_d    = in_img_d_q;
    act_d_d       = act_d_q;
    hs_d_d        = hs_d_q;
    vs_d_d        = vs_d_q;
    vga_rgb_d     = vga_rgb_q;
    blank_n_d     = blank_n_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
`ifdef VMEM_SCAN_TESTPAT_EN
    bar_d_d       = bar_d_q;
`endif
    if (tick) begin
      div_cnt_d = '0;
      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + V_W'(1);
      end else begin
        hcnt_d = hcnt_q + H_W'(1);
      end
      // Address advances after every in-image pixel and saturates on the
      // last one, so it parks through borders and never overruns the image.
      if (at_origin) begin
        pxl_addr_d    = '0;
        frame_start_d = 1'b1;
      end else if (in_img_d_q && (pxl_addr_q != ADDR_LAST)) begin
        pxl_addr_d = pxl_addr_q + 18'd1;
      end
      in_img_d_d = in_img;
      act_d_d    = act;
      hs_d_d     = hs;
      vs_d_d     = vs;
`ifdef VMEM_SCAN_TESTPAT_EN
      bar_d_d    = bar;
`endif
      vga_rgb_d  = pix_show ? pix_src : 24'h0;
      blank_n_d  = act_d_q;
      hsync_d    = ~hs_d_q;
      vsync_d    = ~vs_d_q;
    end
  end

  // State registers; reset and display-disable both return to the idle state.
  always_ff @(posedge clk) begin
    if (reset || !en) begin
      div_cnt_q     <= '0;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      pxl_addr_q    <= '0;
      frame_start_q <= 1'b0;
      in_img_d_q    <= 1'b0;
      act_d_q       <= 1'b0;
      hs_d_q        <= 1'b0;
      vs_d_q        <= 1'b0;
      vga_rgb_q     <= '0;
      blank_n_q     <= 1'b0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
`ifdef VMEM_SCAN_TESTPAT_EN
      bar_d_q       <= '0;
`endif
    end else begin
      div_cnt_q     <= div_cnt_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      pxl_addr_q    <= pxl_addr_d;
      frame_start_q <= frame_start_d;
      in_img_d_q    <= in_img_d_d;
      act_d_q       <= act_d_d;
      hs_d_q        <= hs_d_d;
      vs_d_q        <= vs_d_d;
      vga_rgb_q     <= vga_rgb_d;
      blank_n_q     <= blank_n_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
`ifdef VMEM_SCAN_TESTPAT_EN
      bar_d_q       <= bar_d_d;
`endif
    end
  end

  assign pxlAddr     = pxl_addr_q;
  assign frame_start = frame_start_q;
  assign vga_r       = vga_rgb_q[23:16];
  assign vga_g       = vga_rgb_q[15:8];
  assign vga_b       = vga_rgb_q[7:0];
  assign blank_n     = blank_n_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;

endmodule
